// File: rtl/traffic_actuated_ctrl.sv
// Sensor-actuated two-road (NS/EW) intersection controller.
// Phase lengths are counted in prescaled ticks. Cross-road requests are
// latched, so green stays on a road until the other road has demand.
// Also provides an emergency preempt that forces NS green, and a night
// flash mode that is entered only at the end of an all-red.
//
// state | code | meaning
// ------+------+-----------------------------------------------
// NS_G  |  0   | NS green, EW red (rest state, reset state)
// NS_Y  |  1   | NS yellow, EW red
// AR_A  |  2   | all red after NS, then EW green (or NS / flash)
// EW_G  |  3   | EW green, NS red
// EW_Y  |  4   | EW yellow, NS red
// AR_B  |  5   | all red after EW, then NS green (or flash)
// FLASH |  6   | night flash, lamps blink once per tick
// (7)   |  -   | illegal, recovers to AR_B on the next clk
module traffic_actuated_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int CNT_W     = 6,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 15,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       nscar,
  input  logic       ewcar,
  input  logic       preempt,
  input  logic       flash_en,
  output logic [5:0] lights,
  output logic [2:0] phase,
  output logic       ns_pend,
  output logic       ew_pend
);

  localparam logic [2:0] S_NS_G  = 3'd0;
  localparam logic [2:0] S_NS_Y  = 3'd1;
  localparam logic [2:0] S_AR_A  = 3'd2;
  localparam logic [2:0] S_EW_G  = 3'd3;
  localparam logic [2:0] S_EW_Y  = 3'd4;
  localparam logic [2:0] S_AR_B  = 3'd5;
  localparam logic [2:0] S_FLASH = 3'd6;

  // lamp order {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  localparam logic [5:0] L_NS_G   = 6'b001100;
  localparam logic [5:0] L_NS_Y   = 6'b010100;
  localparam logic [5:0] L_EW_G   = 6'b100001;
  localparam logic [5:0] L_EW_Y   = 6'b100010;
  localparam logic [5:0] L_ALLRED = 6'b100100;
  localparam logic [5:0] L_FL_ON  = 6'b010100;
  localparam logic [5:0] L_DARK   = 6'b000000;

  // prescaler must hold TICK_DIV-1; a 1-bit counter is kept even for TICK_DIV=1
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  // e = elapsed+1 is evaluated one bit wider so a saturated counter cannot wrap
  localparam int EW = CNT_W + 1;
  localparam logic [CNT_W-1:0] EL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EL_ONE = CNT_W'(1);
  localparam logic [EW-1:0]    E_ONE  = EW'(1);
  localparam logic [EW-1:0]    G_MIN  = EW'(GREEN_MIN);
  localparam logic [EW-1:0]    G_MAX  = EW'(GREEN_MAX);
  localparam logic [EW-1:0]    Y_T    = EW'(YELLOW_T);
  localparam logic [EW-1:0]    AR_T   = EW'(ALLRED_T);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             state_chg;
  logic [PS_W-1:0]  prescaler;
  logic [CNT_W-1:0] elapsed;
  logic [EW-1:0]    e;
  logic             tick;
  logic             blink;
  logic             ns_green_done;
  logic             ew_green_done;

  assign tick = (prescaler == PS_LAST);
  assign e    = {1'b0, elapsed} + E_ONE;

  // actuated gap-out (own road empty after minimum) or max-out, both need cross demand
  assign ns_green_done = ew_pend && (((e >= G_MIN) && !nscar) || (e >= G_MAX));
  assign ew_green_done = ns_pend && (((e >= G_MIN) && !ewcar) || (e >= G_MAX));

  // next-state decision; every timed exit is taken only on a tick
  always_comb begin
    state_nxt = state;
    case (state)
      S_NS_G: begin
        if (tick && !preempt && ns_green_done) state_nxt = S_NS_Y;
      end
      S_NS_Y: begin
        if (tick && (e == Y_T)) state_nxt = S_AR_A;
      end
      S_AR_A: begin
        if (tick && (e == AR_T)) begin
          if (flash_en)     state_nxt = S_FLASH;
          else if (preempt) state_nxt = S_NS_G;
          else              state_nxt = S_EW_G;
        end
      end
      S_EW_G: begin
        // preempt cuts EW green short regardless of the minimum
        if (tick && (preempt || ew_green_done)) state_nxt = S_EW_Y;
      end
      S_EW_Y: begin
        if (tick && (e == Y_T)) state_nxt = S_AR_B;
      end
      S_AR_B: begin
        if (tick && (e == AR_T)) begin
          if (flash_en) state_nxt = S_FLASH;
          else          state_nxt = S_NS_G;
        end
      end
      S_FLASH: begin
        if (tick && !flash_en) state_nxt = S_AR_B;
      end
      default: state_nxt = S_AR_B;
    endcase
  end

  assign state_chg = (state_nxt != state);

  // state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_NS_G;
    else      state <= state_nxt;
  end

  // prescaler and elapsed-tick counter, both restart on every state change
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      prescaler <= '0;
      elapsed   <= '0;
    end else if (state_chg) begin
      prescaler <= '0;
      elapsed   <= '0;
    end else if (tick) begin
      prescaler <= '0;
      if (elapsed != EL_MAX) elapsed <= elapsed + EL_ONE;
    end else begin
      prescaler <= prescaler + PS_ONE;
    end
  end

  // flash blink phase: starts lit on entry, toggles each tick while flashing
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      blink <= 1'b1;
    end else if ((state_nxt == S_FLASH) && (state != S_FLASH)) begin
      blink <= 1'b1;
    end else if ((state == S_FLASH) && tick) begin
      blink <= ~blink;
    end
  end

  // request latches; clearing on entry to the road's own green wins over a set
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ns_pend <= 1'b0;
      ew_pend <= 1'b0;
    end else begin
      if ((state_nxt == S_NS_G) && (state != S_NS_G)) ns_pend <= 1'b0;
      else if (nscar && (state != S_NS_G))           ns_pend <= 1'b1;

      if ((state_nxt == S_EW_G) && (state != S_EW_G)) ew_pend <= 1'b0;
      else if (ewcar && (state != S_EW_G))           ew_pend <= 1'b1;
    end
  end

  // lamp decode; any unlisted code shows all red until recovery
  always_comb begin
    lights = L_ALLRED;
    case (state)
      S_NS_G:  lights = L_NS_G;
      S_NS_Y:  lights = L_NS_Y;
      S_AR_A:  lights = L_ALLRED;
      S_EW_G:  lights = L_EW_G;
      S_EW_Y:  lights = L_EW_Y;
      S_AR_B:  lights = L_ALLRED;
      S_FLASH: lights = blink ? L_FL_ON : L_DARK;
      default: lights = L_ALLRED;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_actuated_ctrl.sv
// Directed bench for traffic_actuated_ctrl with short timing parameters
// (TICK_DIV=2, GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1).
module tb_traffic_actuated_ctrl;

  logic       clk;
  logic       clr;
  logic       nscar;
  logic       ewcar;
  logic       preempt;
  logic       flash_en;
  logic [5:0] lights;
  logic [2:0] phase;
  logic       ns_pend;
  logic       ew_pend;

  int checks   = 0;
  int failures = 0;
  int n;
  int bad;

  localparam logic [2:0] P_NS_G  = 3'd0;
  localparam logic [2:0] P_NS_Y  = 3'd1;
  localparam logic [2:0] P_AR_A  = 3'd2;
  localparam logic [2:0] P_EW_G  = 3'd3;
  localparam logic [2:0] P_EW_Y  = 3'd4;
  localparam logic [2:0] P_AR_B  = 3'd5;
  localparam logic [2:0] P_FLASH = 3'd6;

  localparam logic [5:0] L_NS_G   = 6'b001100;
  localparam logic [5:0] L_NS_Y   = 6'b010100;
  localparam logic [5:0] L_EW_G   = 6'b100001;
  localparam logic [5:0] L_EW_Y   = 6'b100010;
  localparam logic [5:0] L_ALLRED = 6'b100100;
  localparam logic [5:0] L_FL_ON  = 6'b010100;
  localparam logic [5:0] L_DARK   = 6'b000000;

  traffic_actuated_ctrl #(
    .TICK_DIV (2),
    .CNT_W    (6),
    .GREEN_MIN(3),
    .GREEN_MAX(6),
    .YELLOW_T (2),
    .ALLRED_T (1)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .nscar   (nscar),
    .ewcar   (ewcar),
    .preempt (preempt),
    .flash_en(flash_en),
    .lights  (lights),
    .phase   (phase),
    .ns_pend (ns_pend),
    .ew_pend (ew_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // counts clock edges until phase leaves ph (bounded)
  task automatic run_phase(input logic [2:0] ph, output int cnt);
    cnt = 0;
    while ((phase === ph) && (cnt < 200)) begin
      step();
      cnt++;
    end
  endtask

  task automatic do_reset();
    nscar    = 1'b0;
    ewcar    = 1'b0;
    preempt  = 1'b0;
    flash_en = 1'b0;
    #2 clr   = 1'b0;
    step();
    step();
    clr = 1'b1;
  endtask

  initial begin
    clr      = 1'b0;
    nscar    = 1'b0;
    ewcar    = 1'b0;
    preempt  = 1'b0;
    flash_en = 1'b0;

    // 1: idle rest on NS green
    do_reset();
    chk("t1_rst_lights", lights, L_NS_G);
    chk("t1_rst_phase", phase, P_NS_G);
    chk("t1_rst_ns_pend", ns_pend, 1'b0);
    chk("t1_rst_ew_pend", ew_pend, 1'b0);
    bad = 0;
    repeat (100) begin
      step();
      if ((lights !== L_NS_G) || (phase !== P_NS_G) || (ns_pend !== 1'b0) || (ew_pend !== 1'b0)) bad++;
    end
    chk("t1_idle_bad_cycles", bad, 0);

    // 2: EW pulse, gap-out at GREEN_MIN
    do_reset();
    ewcar = 1'b1;
    step();
    ewcar = 1'b0;
    chk("t2_ew_pend_set", ew_pend, 1'b1);
    run_phase(P_NS_G, n);
    chk("t2_ns_g_len", n + 1, 6);
    chk("t2_ns_y_phase", phase, P_NS_Y);
    chk("t2_ns_y_lights", lights, L_NS_Y);
    run_phase(P_NS_Y, n);
    chk("t2_ns_y_len", n, 4);
    chk("t2_ar_a_lights", lights, L_ALLRED);
    run_phase(P_AR_A, n);
    chk("t2_ar_a_len", n, 2);
    chk("t2_ew_g_phase", phase, P_EW_G);
    chk("t2_ew_g_lights", lights, L_EW_G);
    chk("t2_ew_pend_clr", ew_pend, 1'b0);

    // 4: preempt on EW green entry, then NS held under preempt
    preempt = 1'b1;
    run_phase(P_EW_G, n);
    chk("t4_ew_g_len", n, 2);
    chk("t4_ew_y_phase", phase, P_EW_Y);
    chk("t4_ew_y_lights", lights, L_EW_Y);
    run_phase(P_EW_Y, n);
    chk("t4_ew_y_len", n, 4);
    chk("t4_ar_b_phase", phase, P_AR_B);
    chk("t4_ar_b_lights", lights, L_ALLRED);
    run_phase(P_AR_B, n);
    chk("t4_ar_b_len", n, 2);
    chk("t4_ns_g_phase", phase, P_NS_G);
    ewcar = 1'b1;
    step();
    ewcar = 1'b0;
    chk("t4_ew_pend_set", ew_pend, 1'b1);
    bad = 0;
    repeat (19) begin
      step();
      if (phase !== P_NS_G) bad++;
    end
    chk("t4_ns_held_bad", bad, 0);
    chk("t4_ew_pend_held", ew_pend, 1'b1);
    preempt = 1'b0;
    run_phase(P_NS_G, n);
    chk("t4_release_len", n, 2);
    chk("t4_release_phase", phase, P_NS_Y);

    // 3: NS traffic present, max-out at GREEN_MAX
    do_reset();
    nscar = 1'b1;
    ewcar = 1'b1;
    step();
    ewcar = 1'b0;
    n = 1;
    bad = 0;
    while ((phase === P_NS_G) && (n < 200)) begin
      if (ns_pend !== 1'b0) bad++;
      step();
      n++;
    end
    chk("t3_ns_g_len", n, 12);
    chk("t3_ns_pend_in_ns_g", bad, 0);
    chk("t3_ns_y_phase", phase, P_NS_Y);
    chk("t3_ns_pend_entry", ns_pend, 1'b0);
    step();
    chk("t3_ns_pend_set", ns_pend, 1'b1);
    run_phase(P_NS_Y, n);
    chk("t3_ns_y_rest", n, 3);
    nscar = 1'b0;

    // 5: flash entered at end of AR_A
    do_reset();
    ewcar = 1'b1;
    step();
    ewcar = 1'b0;
    flash_en = 1'b1;
    run_phase(P_NS_G, n);
    chk("t5_ns_g_len", n + 1, 6);
    run_phase(P_NS_Y, n);
    chk("t5_ns_y_len", n, 4);
    run_phase(P_AR_A, n);
    chk("t5_ar_a_len", n, 2);
    chk("t5_flash_phase", phase, P_FLASH);
    chk("t5_blink0", lights, L_FL_ON);
    step();
    chk("t5_blink1", lights, L_FL_ON);
    step();
    chk("t5_blink2", lights, L_DARK);
    step();
    chk("t5_blink3", lights, L_DARK);
    step();
    chk("t5_blink4", lights, L_FL_ON);
    flash_en = 1'b0;
    run_phase(P_FLASH, n);
    chk("t5_flash_exit_len", n, 2);
    chk("t5_ar_b_phase", phase, P_AR_B);
    run_phase(P_AR_B, n);
    chk("t5_ar_b_len", n, 2);
    chk("t5_ns_g_lights", lights, L_NS_G);
    chk("t5_ns_g_phase", phase, P_NS_G);

    // 6: async reset in EW yellow with both requests latched
    do_reset();
    ewcar = 1'b1;
    step();
    ewcar = 1'b0;
    run_phase(P_NS_G, n);
    nscar = 1'b1;
    step();
    nscar = 1'b0;
    chk("t6_ns_pend_set", ns_pend, 1'b1);
    run_phase(P_NS_Y, n);
    run_phase(P_AR_A, n);
    chk("t6_ew_g_phase", phase, P_EW_G);
    run_phase(P_EW_G, n);
    chk("t6_ew_g_len", n, 6);
    chk("t6_ew_y_phase", phase, P_EW_Y);
    ewcar = 1'b1;
    step();
    ewcar = 1'b0;
    chk("t6_ew_pend_set", ew_pend, 1'b1);
    chk("t6_ns_pend_kept", ns_pend, 1'b1);
    chk("t6_still_ew_y", phase, P_EW_Y);
    #3 clr = 1'b0;
    #1;
    chk("t6_async_lights", lights, L_NS_G);
    chk("t6_async_phase", phase, P_NS_G);
    chk("t6_async_ns_pend", ns_pend, 1'b0);
    chk("t6_async_ew_pend", ew_pend, 1'b0);
    step();
    clr = 1'b1;
    ewcar = 1'b1;
    step();
    ewcar = 1'b0;
    run_phase(P_NS_G, n);
    chk("t6_ns_g_restart_len", n + 1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
